// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I fetch front end with a small prefetch FIFO.
// Issues word reads, buffers in-order responses, hands {instr, pc} to decode.
//
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   redirect_valid, redirect_pc   : load a new fetch PC (branch/jump)
//   imem_req_valid/ready/addr     : instruction memory read request
//   imem_rsp_valid/data           : in-order read data, no backpressure
//   instr_valid/ready, instr, pc  : show-ahead instruction stream to decode
//   misaligned_err                : sticky until an aligned redirect or rst
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        misaligned_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    typedef enum logic {RUN, ERR} state_t;

    state_t        state;
    state_t        state_next;
    logic          rst_hold;
    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW:0]   credit_used;

    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [31:0]   fifo_pc   [FIFO_DEPTH];

    logic req_hs;
    logic rsp_drop;
    logic push;
    logic pop;
    logic redirect_bad;

    assign redirect_bad = redirect_pc[1:0] != 2'b00;
    assign credit_used  = {1'b0, outstanding} + {1'b0, count};
    assign req_hs       = imem_req_valid && imem_req_ready;
    assign rsp_drop     = drop_cnt != '0;
    assign pop          = instr_valid && instr_ready;

    // Responses landing in a redirect cycle belong to the old path.
    assign push = imem_rsp_valid && !rsp_drop && !redirect_valid
               && (state == RUN);

    assign outstanding_next = outstanding + CW'(req_hs)
                            - CW'(imem_rsp_valid);

    assign imem_req_addr = fetch_pc;
    assign instr         = fifo_data[rd_ptr];
    assign instr_pc      = fifo_pc[rd_ptr];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state: any redirect decides the mode, last one wins.
    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = redirect_bad ? ERR : RUN;
        end
    end

    // Outputs decoded from registered state only.
    // rst_hold keeps requests quiet while rst is held past the first edge.
    always_comb begin
        imem_req_valid = 1'b0;
        instr_valid    = 1'b0;
        misaligned_err = 1'b0;
        unique case (1'b1)
            (state == RUN): begin
                imem_req_valid = !rst_hold && (credit_used < DEPTH_W);
                instr_valid    = count != '0;
            end
            (state == ERR): begin
                misaligned_err = 1'b1;
            end
            default: ;
        endcase
    end

    // Counters, pointers and PCs
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_hold    <= 1'b1;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            rst_hold    <= 1'b0;
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                // Everything still in flight after this edge is stale.
                fetch_pc <= redirect_pc;
                rsp_pc   <= redirect_pc;
                drop_cnt <= outstanding_next;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (req_hs) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (imem_rsp_valid && rsp_drop) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
                if (push) begin
                    rsp_pc <= rsp_pc + 32'd4;
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= imem_rsp_data;
            fifo_pc[wr_ptr]   <= rsp_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed bench for instr_fetch_unit.
// Memory model answers addr ^ A5A5_0000 after a programmable latency.
module tb_instr_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        misaligned_err;

    int n_tests;
    int n_fail;
    int cyc;
    int lat;

    logic [31:0] pend_addr [$];
    int          pend_t    [$];
    logic [31:0] acc_pc    [$];
    logic [31:0] acc_data  [$];

    instr_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .misaligned_err (misaligned_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes before the edge, update memory after.
    task automatic step();
        logic hs;
        logic rc;
        hs = imem_req_valid && imem_req_ready;
        rc = imem_rsp_valid;
        if (instr_valid && instr_ready) begin
            acc_pc.push_back(instr_pc);
            acc_data.push_back(instr);
        end
        @(posedge clk);
        cyc++;
        if (rst) begin
            pend_addr.delete();
            pend_t.delete();
        end else begin
            if (rc) begin
                void'(pend_addr.pop_front());
                void'(pend_t.pop_front());
            end
            if (hs) begin
                pend_addr.push_back(imem_req_addr);
                pend_t.push_back(cyc);
            end
        end
        #1;
        chk("credit", 32'(pend_addr.size() <= 2), 32'd1);
        if (pend_addr.size() > 0 && cyc >= pend_t[0] + lat - 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pend_addr[0] ^ KEY;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        steps(2);
        rst = 1'b0;
        step();
        acc_pc.delete();
        acc_data.delete();
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic clear_acc();
        acc_pc.delete();
        acc_data.delete();
    endtask

    // Accepted stream must be gap-free from start with matching data.
    task automatic check_seq(input string tag, input logic [31:0] start,
                             input int nmin);
        logic [31:0] pc;
        chk({tag, "_len"}, 32'(acc_pc.size() >= nmin), 32'd1);
        pc = start;
        foreach (acc_pc[i]) begin
            chk({tag, "_pc"}, acc_pc[i], pc);
            chk({tag, "_data"}, acc_data[i], pc ^ KEY);
            pc = pc + 32'd4;
        end
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        cyc            = 0;
        lat            = 1;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        instr_ready    = 1'b1;

        // Reset values, then first request at RESET_PC
        steps(2);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_err", 32'(misaligned_err), 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
        chk("post_rst_addr", imem_req_addr, 32'h0);
        chk("post_rst_instr_valid", 32'(instr_valid), 32'd0);

        // Streaming, latency 1
        clear_acc();
        steps(20);
        check_seq("stream", 32'h0, 6);

        // Decode stalled: FIFO fills, requests stop, then drain
        instr_ready = 1'b0;
        do_reset();
        steps(6);
        chk("stall_instr_valid", 32'(instr_valid), 32'd1);
        chk("stall_pc", instr_pc, 32'h0);
        chk("stall_instr", instr, 32'h0 ^ KEY);
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        instr_ready = 1'b1;
        steps(12);
        check_seq("drain", 32'h0, 4);

        // Latency 3: two requests in flight, then redirect
        lat = 3;
        do_reset();
        steps(2);
        chk("lat3_full", 32'(imem_req_valid), 32'd0);
        redirect(32'h100);
        clear_acc();
        steps(25);
        check_seq("redir100", 32'h100, 4);

        // Redirect coincides with rsp for 0x4 and handshake at 0x8
        lat = 2;
        do_reset();
        step();
        imem_req_ready = 1'b0;
        step();
        imem_req_ready = 1'b1;
        steps(2);
        chk("coinc_req_valid", 32'(imem_req_valid), 32'd1);
        chk("coinc_addr", imem_req_addr, 32'h8);
        chk("coinc_rsp", 32'(imem_rsp_valid), 32'd1);
        chk("coinc_rsp_data", imem_rsp_data, 32'h4 ^ KEY);
        redirect(32'h40);
        clear_acc();
        steps(20);
        check_seq("redir40", 32'h40, 4);

        // Misaligned redirect, then recovery
        lat = 1;
        do_reset();
        steps(3);
        redirect(32'h102);
        chk("err_set", 32'(misaligned_err), 32'd1);
        chk("err_req_valid", 32'(imem_req_valid), 32'd0);
        chk("err_instr_valid", 32'(instr_valid), 32'd0);
        steps(4);
        chk("err_sticky", 32'(misaligned_err), 32'd1);
        chk("err_req_hold", 32'(imem_req_valid), 32'd0);
        redirect(32'h200);
        chk("err_clear", 32'(misaligned_err), 32'd0);
        chk("err_resume_valid", 32'(imem_req_valid), 32'd1);
        chk("err_resume_addr", imem_req_addr, 32'h200);
        clear_acc();
        steps(20);
        check_seq("redir200", 32'h200, 6);

        // Reset mid-stream with entries buffered
        instr_ready = 1'b0;
        do_reset();
        steps(6);
        chk("mid_buffered", 32'(instr_valid), 32'd1);
        rst = 1'b1;
        step();
        chk("mid_rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
        rst = 1'b0;
        step();
        chk("mid_rst_req", 32'(imem_req_valid), 32'd1);
        chk("mid_rst_addr", imem_req_addr, 32'h0);
        instr_ready = 1'b1;
        clear_acc();
        steps(20);
        check_seq("after_rst", 32'h0, 6);

        // PC wrap at the top of the address space
        redirect(32'hFFFF_FFF8);
        clear_acc();
        steps(20);
        check_seq("wrap", 32'hFFFF_FFF8, 5);

        // Back-to-back redirects: the last one wins
        steps(3);
        redirect(32'h300);
        redirect(32'h400);
        clear_acc();
        steps(20);
        check_seq("b2b", 32'h400, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
